// File: rtl/fir_pkg.sv
// Shared constants for the FIR filter datapath.
// Accumulator/sample widths, coefficient Q-format and clip limits.
package fir_pkg;

    localparam int FIR_ACC_W     = 40;
    localparam int FIR_SAMPLE_W  = 16;
    localparam int FIR_COEF_FRAC = 15;

    // Largest and smallest representable output samples
    localparam logic signed [FIR_SAMPLE_W-1:0] SAT_MAX =
        {1'b0, {(FIR_SAMPLE_W-1){1'b1}}};
    localparam logic signed [FIR_SAMPLE_W-1:0] SAT_MIN =
        {1'b1, {(FIR_SAMPLE_W-1){1'b0}}};

endpackage

// File: rtl/fir_sat_round.sv
// Combinational round-half-up and clip helpers for the quantizer.
// The round path and the clip path are independent so a register fits between.
module fir_sat_round
    import fir_pkg::*;
#(
    parameter  int IN_W  = FIR_ACC_W,
    parameter  int OUT_W = FIR_SAMPLE_W,
    parameter  int SHIFT = FIR_COEF_FRAC,
    localparam int RW    = IN_W + 1 - SHIFT
) (
    input  logic [IN_W-1:0]        din_i,
    output logic signed [RW-1:0]   r_o,
    input  logic [RW-1:0]          r_i,
    output logic [OUT_W-1:0]       q_o,
    output logic                   sat_o
);

    localparam int W1 = IN_W + 1;

    logic signed [IN_W:0] ext;
    logic [RW-OUT_W:0]    top;
    logic                 ovf;

    // One extra bit so adding the half-LSB offset can never overflow
    assign ext = $signed({din_i[IN_W-1], din_i});

    if (SHIFT > 0) begin : g_rnd
        localparam logic signed [IN_W:0] HALF = W1'(1) <<< (SHIFT - 1);
        logic signed [IN_W:0] sum;
        assign sum = ext + HALF;
        assign r_o = RW'(sum >>> SHIFT);
    end else begin : g_pass
        assign r_o = RW'(ext);
    end

    // Bits above the output sign must all match the sign, else clip
    assign top = r_i[RW-1:OUT_W-1];
    assign ovf = (|top) & ~(&top);

    // Select clipped extreme or the in-range low bits
    always_comb begin
        q_o   = r_i[OUT_W-1:0];
        sat_o = 1'b0;
        if (ovf) begin
            sat_o = 1'b1;
            if (r_i[RW-1]) begin
                q_o = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                q_o = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/fir_output_quantizer.sv
// Two-stage round/saturate quantizer on the FIR accumulator stream.
// Optional saturation event counter: define FIR_QUANT_SAT_CNT_EN.
module fir_output_quantizer
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_ACC_W,
    parameter int OUT_W = FIR_SAMPLE_W,
    parameter int SHIFT = FIR_COEF_FRAC
`ifdef FIR_QUANT_SAT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    input  logic [IN_W-1:0]  s_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic [OUT_W-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tuser
`ifdef FIR_QUANT_SAT_CNT_EN
    ,
    output logic [CNT_W-1:0] sat_count
`endif
);

    localparam int RW = IN_W + 1 - SHIFT;

    logic             en;
    logic [RW-1:0]    r_d, r_q;
    logic             v1_d, v1_q;
    logic             vo_d, vo_q;
    logic [OUT_W-1:0] data_d, data_q;
    logic             user_d, user_q;

    fir_sat_round #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_round (
        .din_i (s_axis_data_tdata),
        .r_o   (r_d),
        .r_i   (r_q),
        .q_o   (data_d),
        .sat_o (user_d)
    );

    // Whole pipeline advances unless the output slot is full and stalled
    assign en = !vo_q || m_axis_data_tready;

    assign s_axis_data_tready = en && !areset;
    assign v1_d               = s_axis_data_tvalid;
    assign vo_d               = v1_q;

    assign m_axis_data_tvalid = vo_q;
    assign m_axis_data_tdata  = data_q;
    assign m_axis_data_tuser  = user_q;

    // Round stage then saturate stage, both frozen on a stall
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_q    <= '0;
            v1_q   <= 1'b0;
            vo_q   <= 1'b0;
            data_q <= '0;
            user_q <= 1'b0;
        end else if (en) begin
            r_q    <= r_d;
            v1_q   <= v1_d;
            vo_q   <= vo_d;
            data_q <= data_d;
            user_q <= user_d;
        end
    end

`ifdef FIR_QUANT_SAT_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Count clipped samples as they leave; hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (vo_q && m_axis_data_tready && user_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Scoreboard bench for fir_output_quantizer.
// Set FIR_QUANT_SAT_CNT_EN to also check the saturation counter.
module tb_fir_output_quantizer;
    import fir_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_valid;
    logic        s_ready;
    logic [39:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_user;
`ifdef FIR_QUANT_SAT_CNT_EN
    logic [1:0]  sat_count;
    int          cnt_m = 0;
`endif

    always #5 aclk = ~aclk;

    fir_output_quantizer #(
        .IN_W  (FIR_ACC_W),
        .OUT_W (FIR_SAMPLE_W),
        .SHIFT (FIR_COEF_FRAC)
`ifdef FIR_QUANT_SAT_CNT_EN
        ,
        .CNT_W (2)
`endif
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tvalid (s_valid),
        .s_axis_data_tready (s_ready),
        .s_axis_data_tdata  (s_data),
        .m_axis_data_tvalid (m_valid),
        .m_axis_data_tready (m_ready),
        .m_axis_data_tdata  (m_data),
        .m_axis_data_tuser  (m_user)
`ifdef FIR_QUANT_SAT_CNT_EN
        ,
        .sat_count          (sat_count)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic        u;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b1;
    logic [15:0] exp_d_in = '0;
    logic        exp_u_in = 1'b0;
    bit          held_v = 1'b0;
    logic [15:0] held_d;
    logic        held_u;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Independent reference: wide integer round-half-up, then clip
    function automatic logic [16:0] model(input logic [39:0] din);
        longint x, r;
        x = longint'($signed(din));
        r = (x + 64'sd16384) >>> 15;
        if (r > 32767) return {1'b1, SAT_MAX};
        if (r < -32768) return {1'b1, SAT_MIN};
        return {1'b0, r[15:0]};
    endfunction

    always @(posedge aclk) cyc++;

    // Monitor: push on input handshake, pop/compare on output handshake
    always @(negedge aclk) begin
        if (areset) begin
            held_v = 1'b0;
`ifdef FIR_QUANT_SAT_CNT_EN
            cnt_m = 0;
`endif
        end else begin
            exp_t e;
            if (held_v) begin
                check("hold_valid", 64'(m_valid), 1);
                check("hold_data", 64'(m_data), 64'(held_d));
                check("hold_user", 64'(m_user), 64'(held_u));
            end
            check("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
            if (s_valid && s_ready)
                sb.push_back('{exp_d_in, exp_u_in, cyc, lat_mode});
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(m_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("data", 64'(m_data), 64'(e.d));
                    check("user", 64'(m_user), 64'(e.u));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 2);
                end
            end
            held_v = m_valid && !m_ready;
            held_d = m_data;
            held_u = m_user;
`ifdef FIR_QUANT_SAT_CNT_EN
            check("sat_count", 64'(sat_count), 64'(cnt_m));
            if (m_valid && m_ready && m_user && cnt_m < 3) cnt_m++;
`endif
        end
    end

    task automatic drive(input logic [39:0] din, input logic [15:0] d,
                         input logic u);
        int  n;
        bit  ok;
        n = 0;
        s_valid  = 1'b1;
        s_data   = din;
        exp_d_in = d;
        exp_u_in = u;
        forever begin
            @(negedge aclk);
            ok = s_ready;
            @(posedge aclk);
            #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                check("drive_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drive_m(input logic [39:0] din);
        logic [16:0] m;
        m = model(din);
        drive(din, m[15:0], m[16]);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge aclk);
            w++;
        end
        #1;
        check("drain", 64'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rnd;
        areset  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #2 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_data", 64'(m_data), 0);
        check("rst_m_user", 64'(m_user), 0);
        check("rst_s_ready", 64'(s_ready), 0);
        areset = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(s_ready), 1);
        @(posedge aclk);
        #1;

        // Rounding and saturation corner vectors, back to back
        drive(40'h00_0000_4000, 16'h0001, 1'b0);
        drive(40'h00_0000_3FFF, 16'h0000, 1'b0);
        drive(40'hFF_FFFF_C000, 16'h0000, 1'b0);
        drive(40'hFF_FFFF_BFFF, 16'hFFFF, 1'b0);
        drive(40'h7F_FFFF_FFFF, 16'h7FFF, 1'b1);
        drive(40'h80_0000_0000, 16'h8000, 1'b1);
        drive(40'h00_3FFF_8000, 16'h7FFF, 1'b0);
        drive(40'h00_3FFF_7FFF, 16'h7FFF, 1'b0);
        // Half-LSB round-up lands exactly on 2^15 and clips
        drive(40'h00_3FFF_C000, 16'h7FFF, 1'b1);
        drive(40'h00_3FFF_BFFF, 16'h7FFF, 1'b0);
        drive(40'hFF_C000_0000, 16'h8000, 1'b0);
        drive(40'hFF_BFFF_BFFF, 16'h8000, 1'b1);
        drain();

        // Eight back-to-back random samples, ready held high
        for (int i = 0; i < 8; i++) begin
            rnd = {$urandom, $urandom};
            if (i[0]) rnd = {{40{rnd[24]}}, rnd[23:0]};
            drive_m(rnd[39:0]);
        end
        drain();

        // Backpressure mid-stream
        lat_mode = 1'b0;
        drive(40'd1 << 15, 16'd1, 1'b0);
        drive(40'd2 << 15, 16'd2, 1'b0);
        fork
            begin
                drive(40'd3 << 15, 16'd3, 1'b0);
                drive(40'd4 << 15, 16'd4, 1'b0);
            end
            begin
                @(posedge aclk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        lat_mode = 1'b1;

        // Reset with two samples in flight
        drive(40'd5 << 15, 16'd5, 1'b0);
        drive(40'd6 << 15, 16'd6, 1'b0);
        check("inflight_valid", 64'(m_valid), 1);
        areset = 1'b1;
        #1;
        check("async_rst_valid", 64'(m_valid), 0);
        check("async_rst_ready", 64'(s_ready), 0);
        sb.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        idle(4);
        drive(40'd7 << 15, 16'd7, 1'b0);
        drain();

`ifdef FIR_QUANT_SAT_CNT_EN
        // Five clipped samples, one of them stalled at the output
        lat_mode = 1'b0;
        drive_m(40'h7F_FFFF_FFFF);
        drive_m(40'h80_0000_0000);
        fork
            begin
                drive_m(40'h7F_FFFF_FFFF);
                drive_m(40'h80_0000_0000);
                drive_m(40'h00_3FFF_C000);
            end
            begin
                @(posedge aclk);
                #1 m_ready = 1'b0;
                repeat (3) @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        idle(2);
        check("sat_count_final", 64'(sat_count), 3);
        lat_mode = 1'b1;
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
